// File: rtl/sponge_absorb_packer.sv
// ---------------------------------------------------------------------------
// sponge_absorb_packer
//
// Purpose:
//   Packs a handshaked stream of IN_WIDTH-bit message words into RATE_WIDTH
//   sponge blocks. It applies multi-rate padding (PAD_BEGINNING right after
//   the last message byte, PAD_ENDING OR-ed into the top byte of the final
//   block). It also emits an extra all-padding block when the message fills
//   the last block exactly. When the final block has been consumed it pulses
//   start_squeeze.
//
// Ports:
//   clk            clock, all logic on posedge
//   clear_n        asynchronous active-low reset
//   abort          synchronous: drop partial message, back to ABSORB slot 0
//   in_data        message word, byte 0 = bits[7:0] = earliest byte
//   in_valid       in_data valid
//   in_ready       word accepted when in_valid && in_ready
//   in_last        word is last of message
//   in_nbytes      valid bytes in last word (saturates at IN_BYTES)
//   out_block      packed block, first word at bits[IN_WIDTH-1:0]
//   out_valid      out_block valid, held until out_ready
//   out_ready      block consumed when out_valid && out_ready
//   out_last       out_block is the final (padded) block of the message
//   start_squeeze  one-cycle pulse the cycle after the final block handshake
//   block_count    blocks emitted for the current message (wraps)
// ---------------------------------------------------------------------------
module sponge_absorb_packer #(
  parameter int unsigned IN_WIDTH      = 64,
  parameter int unsigned RATE_WIDTH    = 256,
  parameter logic [7:0]  PAD_BEGINNING = 8'h1f,
  parameter logic [7:0]  PAD_ENDING    = 8'h80,
  localparam int unsigned IN_BYTES     = IN_WIDTH / 8,
  localparam int unsigned NB_W         = $clog2(IN_BYTES) + 1
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  abort,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [NB_W-1:0]       in_nbytes,
  output logic [RATE_WIDTH-1:0] out_block,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  start_squeeze,
  output logic [15:0]           block_count
);

  localparam int unsigned WORDS      = RATE_WIDTH / IN_WIDTH;
  localparam int unsigned RATE_BYTES = RATE_WIDTH / 8;
  localparam int unsigned SLOT_W     = $clog2(WORDS);
  localparam int unsigned P_W        = $clog2(RATE_BYTES + 1);

  typedef enum logic [1:0] {
    ST_ABSORB,
    ST_EMIT,
    ST_PAD_BLOCK,
    ST_SQUEEZE
  } state_t;

  state_t                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [RATE_WIDTH-1:0]   buf_q, buf_d;
  logic                    last_q, last_d;   // block in buf is the final one
  logic                    pend_q, pend_d;   // extra padding block still owed
  logic [15:0]             cnt_q, cnt_d;
  logic                    live_q;           // holds in_ready low until first clk after reset

  logic [NB_W-1:0]         nb_sat;
  logic [P_W-1:0]          pad_pos;
  logic [IN_WIDTH-1:0]     masked_word;
  logic [RATE_WIDTH-1:0]   absorb_blk;
  logic [RATE_WIDTH-1:0]   pad_blk;
  logic                    accept;

  assign nb_sat  = (in_nbytes > NB_W'(IN_BYTES)) ? NB_W'(IN_BYTES) : in_nbytes;
  // Absolute byte position of the first padding byte within the block.
  assign pad_pos = P_W'(slot_q) * P_W'(IN_BYTES) + P_W'(nb_sat);
  assign pad_blk = {PAD_ENDING, {(RATE_WIDTH-16){1'b0}}, PAD_BEGINNING};

  // Bytes past the valid count of the last word are forced to zero so the
  // padding bytes can simply be OR-ed in afterwards.
  generate
    for (genvar gi = 0; gi < int'(IN_BYTES); gi++) begin : g_mask
      assign masked_word[gi*8 +: 8] =
        (!in_last || (NB_W'(gi) < nb_sat)) ? in_data[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Buffer contents after writing the current word into its slot, with
  // padding applied when the word ends the message.
  always_comb begin
    absorb_blk = buf_q;
    for (int w = 0; w < int'(WORDS); w++) begin
      if (slot_q == SLOT_W'(w)) begin
        absorb_blk[w*IN_WIDTH +: IN_WIDTH] = masked_word;
      end
    end
    if (in_last) begin
      for (int b = 0; b < int'(RATE_BYTES); b++) begin
        if (pad_pos == P_W'(b)) begin
          absorb_blk[b*8 +: 8] = absorb_blk[b*8 +: 8] | PAD_BEGINNING;
        end
      end
      // pad_pos == RATE_BYTES means the block is full of data; the
      // terminating padding then goes into a separate block.
      if (pad_pos < P_W'(RATE_BYTES)) begin
        absorb_blk[RATE_WIDTH-1 -: 8] = absorb_blk[RATE_WIDTH-1 -: 8] | PAD_ENDING;
      end
    end
  end

  assign in_ready      = live_q && (state_q == ST_ABSORB);
  assign out_valid     = (state_q == ST_EMIT);
  assign out_last      = out_valid && last_q;
  assign out_block     = buf_q;
  assign start_squeeze = (state_q == ST_SQUEEZE);
  assign block_count   = cnt_q;
  assign accept        = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    buf_d   = buf_q;
    last_d  = last_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_ABSORB;
      slot_d  = '0;
      buf_d   = '0;
      last_d  = 1'b0;
      pend_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_ABSORB: begin
          if (accept) begin
            buf_d = absorb_blk;
            if (in_last) begin
              last_d  = (pad_pos < P_W'(RATE_BYTES));
              pend_d  = !(pad_pos < P_W'(RATE_BYTES));
              state_d = ST_EMIT;
            end else if (slot_q == SLOT_W'(WORDS - 1)) begin
              last_d  = 1'b0;
              state_d = ST_EMIT;
            end else begin
              slot_d = slot_q + SLOT_W'(1);
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            buf_d  = '0;
            slot_d = '0;
            cnt_d  = cnt_q + 16'd1;
            if (pend_q) begin
              pend_d  = 1'b0;
              state_d = ST_PAD_BLOCK;
            end else if (last_q) begin
              state_d = ST_SQUEEZE;
            end else begin
              state_d = ST_ABSORB;
            end
          end
        end
        ST_PAD_BLOCK: begin
          buf_d   = pad_blk;
          last_d  = 1'b1;
          state_d = ST_EMIT;
        end
        ST_SQUEEZE: begin
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = ST_ABSORB;
        end
        default: state_d = ST_ABSORB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_ABSORB;
      slot_q  <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sponge_absorb_packer.sv
module tb_sponge_absorb_packer;

  typedef logic [7:0] u8_t;

  logic         clk;
  logic         clear_n;
  logic         abort;
  logic [63:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [3:0]   in_nbytes;
  logic [255:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         start_squeeze;
  logic [15:0]  block_count;

  sponge_absorb_packer #(
    .IN_WIDTH(64), .RATE_WIDTH(256), .PAD_BEGINNING(8'h1f), .PAD_ENDING(8'h80)
  ) dut (
    .clk(clk), .clear_n(clear_n), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_nbytes(in_nbytes),
    .out_block(out_block), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .start_squeeze(start_squeeze), .block_count(block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: blocks the DUT still owes, in order.
  logic [255:0] exp_blk[$];
  bit           exp_last[$];
  logic [255:0] got_blk[$];
  bit           sq_next = 1'b0;
  int           mdl_cnt = 0;

  int rdy_mode = 0;   // 0 random, 1 never ready, 2 always ready
  int bp_left  = 0;   // cycles of forced stall while a block is shown
  bit use_gaps = 1'b1;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Padded message -> sequence of expected blocks.
  function automatic void push_expected(input u8_t m[$]);
    u8_t q[$];
    logic [255:0] blk;
    int nblk;
    q = m;
    q.push_back(8'h1f);
    while (q.size() % 32 != 0) q.push_back(8'h00);
    q[q.size()-1] = q[q.size()-1] | 8'h80;
    nblk = q.size() / 32;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 32; i++) blk[i*8 +: 8] = q[b*32 + i];
      exp_blk.push_back(blk);
      exp_last.push_back(b == nblk - 1);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    bit acc;
    int t;
    if (use_gaps) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    in_data = d; in_last = last; in_nbytes = nb; in_valid = 1'b1;
    acc = 1'b0; t = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
      if (!acc && t >= 2000) begin
        n_checks++; n_errors++;
        $display("FAIL send_timeout: got no accept expected accept");
        break;
      end
    end
    in_valid = 1'b0;
    in_data = 64'($urandom());
  endtask

  // Sends up to max_words words of m; a truncated send never asserts in_last.
  task automatic send_msg(input u8_t m[$], input int max_words);
    int len, nw, idx, nb;
    logic [63:0] d;
    len = m.size();
    nw = (len == 0) ? 1 : (len + 7) / 8;
    push_expected(m);
    for (int w = 0; w < nw && w < max_words; w++) begin
      d = {$urandom(), $urandom()};
      for (int b = 0; b < 8; b++) begin
        idx = w * 8 + b;
        if (idx < len) d[b*8 +: 8] = m[idx];
      end
      if (w == nw - 1) begin
        nb = len - w * 8;
        if (nb == 8 && $urandom_range(0, 1) == 1) nb = $urandom_range(8, 15);
        send_word(d, 1'b1, 4'(nb));
      end else begin
        send_word(d, 1'b0, 4'($urandom_range(0, 15)));
      end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_blk.size() != 0 || sq_next) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    n_checks++;
    if (t >= 5000) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d blocks pending expected 0", exp_blk.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_left > 0) begin
        out_ready = 1'b0;
        if (out_valid) bp_left--;
      end else if (rdy_mode == 1) out_ready = 1'b0;
      else if (rdy_mode == 2) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Compare process: checks DUT against the model on every cycle.
  initial begin
    bit sq_now;
    forever begin
      @(negedge clk);
      if (!clear_n) begin
        exp_blk.delete(); exp_last.delete();
        sq_next = 1'b0; mdl_cnt = 0;
      end else begin
        chk("start_squeeze", 256'(start_squeeze), 256'(sq_next));
        chk("block_count", 256'(block_count), 256'(mdl_cnt));
        sq_now = sq_next;
        sq_next = 1'b0;
        if (sq_now) mdl_cnt = 0;
        if (out_valid) begin
          if (exp_blk.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_block: got out_valid=1 expected out_valid=0");
          end else begin
            chk("out_block", out_block, exp_blk[0]);
            chk("out_last", 256'(out_last), 256'(exp_last[0]));
          end
          chk("in_ready_while_emit", 256'(in_ready), 256'(0));
        end
        if (abort) begin
          exp_blk.delete(); exp_last.delete();
          sq_next = 1'b0; mdl_cnt = 0;
        end else if (out_valid && out_ready && exp_blk.size() != 0) begin
          got_blk.push_back(out_block);
          if (exp_last[0]) sq_next = 1'b1;
          void'(exp_blk.pop_front());
          void'(exp_last.pop_front());
          mdl_cnt = (mdl_cnt + 1) % 65536;
        end
      end
    end
  end

  initial begin
    u8_t m[$];
    logic [255:0] padblk;
    int t;
    padblk = {8'h80, 240'h0, 8'h1f};
    clear_n = 1'b0; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; in_nbytes = '0;

    // Reset values
    #12;
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_block", out_block, 256'(0));
    chk("rst_out_last", 256'(out_last), 256'(0));
    chk("rst_squeeze", 256'(start_squeeze), 256'(0));
    chk("rst_block_count", 256'(block_count), 256'(0));
    @(negedge clk); #2;
    clear_n = 1'b1;
    #1 chk("in_ready_before_clk", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    chk("in_ready_after_clk", 256'(in_ready), 256'(1));

    // Empty message
    got_blk.delete(); m.delete();
    send_msg(m, 1000); wait_idle();
    chk("empty_nblk", 256'(got_blk.size()), 256'(1));
    chk("empty_block", got_blk[0], padblk);

    // 31-byte message 0x00..0x1e
    got_blk.delete(); m.delete();
    for (int i = 0; i < 31; i++) m.push_back(u8_t'(i));
    send_msg(m, 1000); wait_idle();
    chk("b31_nblk", 256'(got_blk.size()), 256'(1));
    chk("b31_top", 256'(got_blk[0][255:248]), 256'(8'h9f));
    chk("b31_byte30", 256'(got_blk[0][247:240]), 256'(8'h1e));

    // 32-byte message: full data block then padding block
    got_blk.delete(); m.delete();
    for (int i = 0; i < 32; i++) m.push_back(u8_t'(i));
    send_msg(m, 1000); wait_idle();
    chk("b32_nblk", 256'(got_blk.size()), 256'(2));
    chk("b32_top", 256'(got_blk[0][255:248]), 256'(8'h1f));
    chk("b32_pad", got_blk[1], padblk);

    // 40-byte message with 5-cycle backpressure on the first block
    got_blk.delete(); m.delete();
    for (int i = 0; i < 40; i++) m.push_back(u8_t'(i));
    bp_left = 5; rdy_mode = 2;
    send_msg(m, 1000); wait_idle();
    rdy_mode = 0;
    chk("b40_nblk", 256'(got_blk.size()), 256'(2));
    chk("b40_blk1_b0", 256'(got_blk[0][7:0]), 256'(8'h00));
    chk("b40_blk1_b31", 256'(got_blk[0][255:248]), 256'(8'h1f));
    chk("b40_blk2_b0", 256'(got_blk[1][7:0]), 256'(8'h20));
    chk("b40_blk2_b7", 256'(got_blk[1][63:56]), 256'(8'h27));
    chk("b40_blk2_b8", 256'(got_blk[1][71:64]), 256'(8'h1f));
    chk("b40_blk2_mid", 256'(got_blk[1][247:72]), 256'(0));
    chk("b40_blk2_b31", 256'(got_blk[1][255:248]), 256'(8'h80));

    // Abort while a block is being offered
    rdy_mode = 1; m.delete();
    for (int i = 0; i < 40; i++) m.push_back(u8_t'($urandom()));
    send_msg(m, 4);
    t = 0;
    while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
    chk("abort_setup_valid", 256'(out_valid), 256'(1));
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_drop_valid", 256'(out_valid), 256'(0));
    chk("abort_block_count", 256'(block_count), 256'(0));
    chk("abort_in_ready", 256'(in_ready), 256'(1));
    rdy_mode = 0;
    got_blk.delete(); m.delete();
    for (int i = 0; i < 20; i++) m.push_back(u8_t'($urandom()));
    send_msg(m, 1000); wait_idle();
    chk("post_abort_nblk", 256'(got_blk.size()), 256'(1));

    // Reset after two words of a message
    m.delete();
    for (int i = 0; i < 30; i++) m.push_back(u8_t'($urandom()));
    send_msg(m, 2);
    clear_n = 1'b0;
    #2;
    chk("midrst_out_valid", 256'(out_valid), 256'(0));
    chk("midrst_out_block", out_block, 256'(0));
    chk("midrst_in_ready", 256'(in_ready), 256'(0));
    chk("midrst_block_count", 256'(block_count), 256'(0));
    @(negedge clk); #2 clear_n = 1'b1;
    @(posedge clk); #1;
    got_blk.delete(); m.delete();
    for (int i = 0; i < 12; i++) m.push_back(u8_t'(8'hA0 + i));
    send_msg(m, 1000); wait_idle();
    chk("post_rst_nblk", 256'(got_blk.size()), 256'(1));
    chk("post_rst_b12", 256'(got_blk[0][103:96]), 256'(8'h1f));

    // Randomized messages
    for (int k = 0; k < 40; k++) begin
      int len;
      len = (k < 9) ? (k * 8 + (k % 3)) : $urandom_range(0, 100);
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(u8_t'($urandom()));
      send_msg(m, 1000);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
